// File: rtl/jk_cmd_pkg.sv
// jk_cmd_pkg: shared state/command encodings and priority helpers for jk_cmd_gen
package jk_cmd_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;
  typedef enum logic [1:0] {
    CMD_NONE   = 2'b00,
    CMD_RESET  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_t;
  localparam int IDX_SET    = 0;
  localparam int IDX_RESET  = 1;
  localparam int IDX_TOGGLE = 2;
  function automatic cmd_t prio_cmd(input logic [2:0] stb);
    return stb[IDX_SET] ? CMD_SET : stb[IDX_RESET] ? CMD_RESET : stb[IDX_TOGGLE] ? CMD_TOGGLE : CMD_NONE;
  endfunction
  function automatic logic cmd_held(input cmd_t c, input logic [2:0] stb);
    return (c == CMD_SET) ? stb[IDX_SET] : (c == CMD_RESET) ? stb[IDX_RESET] :
           (c == CMD_TOGGLE) ? stb[IDX_TOGGLE] : 1'b0;
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchroniser plus debounce counter; stb flips after DB_CYCLES disagreeing samples
module debounce_cell #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk_n,
  input  logic clr,
  input  logic req,
  output logic stb,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);
  logic r_s1, r_s2, r_stb, r_rise;
  logic [CW-1:0] r_cnt;
  logic w_flip;
  assign w_flip = (r_s2 != r_stb) && (r_cnt == C_LAST);
  always_ff @(negedge clk_n) begin
    if (clr) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_stb  <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= req;
      r_s2   <= r_s1;
      r_cnt  <= (r_s2 == r_stb || w_flip) ? '0 : r_cnt + 1'b1;
      r_stb  <= r_stb ^ w_flip;
      r_rise <= w_flip & ~r_stb;
    end
  end
  assign stb  = r_stb;
  assign rise = r_rise;
endmodule

// File: rtl/jk_cmd_gen.sv
// jk_cmd_gen: debounced set/reset/toggle buttons to one-cycle J/K commands on the falling clk_n edge.
// Define JK_CMD_GEN_AUTO_REPEAT_EN to re-fire a held command every REPEAT_CYCLES+1 edges.
module jk_cmd_gen
  import jk_cmd_pkg::*;
#(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 16
) (
  input  logic clk_n,
  input  logic clr,
  input  logic req_set,
  input  logic req_reset,
  input  logic req_toggle,
  output logic j,
  output logic k,
  output logic busy
);
  logic [2:0] w_stb, w_rise;
  state_t r_state, w_state_nx;
  cmd_t r_cmd, w_cmd_nx, w_out_nx;
  logic r_j, r_k, r_busy, w_repeat;
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk_n(clk_n), .clr(clr), .req(req_set), .stb(w_stb[IDX_SET]), .rise(w_rise[IDX_SET])
  );
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk_n(clk_n), .clr(clr), .req(req_reset), .stb(w_stb[IDX_RESET]), .rise(w_rise[IDX_RESET])
  );
  debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_db_toggle (
    .clk_n(clk_n), .clr(clr), .req(req_toggle), .stb(w_stb[IDX_TOGGLE]), .rise(w_rise[IDX_TOGGLE])
  );
`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] R_DONE = RW'(REPEAT_CYCLES);
  logic [RW-1:0] r_rep;
  // R_DONE parks the counter so a late re-press of the captured button cannot fire before full release
  assign w_repeat = (r_rep == R_LAST) && cmd_held(r_cmd, w_stb);
  always_ff @(negedge clk_n)
    r_rep <= (clr || r_state != HOLD) ? '0 : (r_rep == R_DONE) ? r_rep : r_rep + 1'b1;
`else
  assign w_repeat = 1'b0;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_cmd_nx   = r_cmd;
    w_out_nx   = CMD_NONE;
    unique case (r_state)
      IDLE: if (|w_stb) begin
        w_state_nx = DRIVE;
        w_cmd_nx   = prio_cmd(w_stb);
        w_out_nx   = w_cmd_nx;
      end
      DRIVE: w_state_nx = HOLD;
      HOLD: if (~|w_stb && ~|w_rise) w_state_nx = IDLE;
        else if (w_repeat) begin
          w_state_nx = DRIVE;
          w_out_nx   = r_cmd;
        end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(negedge clk_n) begin
    if (clr) begin
      r_state <= IDLE;
      r_cmd   <= CMD_NONE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cmd      <= w_cmd_nx;
      {r_j, r_k} <= w_out_nx;
      r_busy     <= (w_state_nx != IDLE);
    end
  end
  assign j    = r_j;
  assign k    = r_k;
  assign busy = r_busy;
endmodule

// File: tb/tb_jk_cmd_gen.sv
// tb_jk_cmd_gen: directed test-plan scenarios plus random button traffic against a behavioural model
module tb_jk_cmd_gen;
  localparam int DB = 4;
  localparam int RP = 16;
`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
  localparam int T1_N = 2;
`else
  localparam int T1_N = 1;
`endif
  logic clk_n = 1'b1, clr = 1'b1, req_set = 1'b0, req_reset = 1'b0, req_toggle = 1'b0;
  logic j, k, busy, q;
  int n_checks = 0, n_errors = 0;
  int edge_no = 0, first_busy = -1, last_busy = -1;
  int p_edge[$];
  logic [1:0] p_val[$];
  logic [2:0] m_line0 = '0, m_line1 = '0, m_stb = '0;
  bit m_win[3][$];
  int m_state = 0, m_hold = 0;
  logic [1:0] m_cmd = 2'b00;
  logic m_j = 1'b0, m_k = 1'b0, m_busy = 1'b0;

  always #5 clk_n = ~clk_n;

  jk_cmd_gen #(.DB_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk_n(clk_n), .clr(clr), .req_set(req_set), .req_reset(req_reset),
    .req_toggle(req_toggle), .j(j), .k(k), .busy(busy)
  );

  // downstream jk_ff stand-in sharing the falling-edge domain
  always @(negedge clk_n)
    q <= clr ? 1'b0 : ({j, k} == 2'b10) ? 1'b1 : ({j, k} == 2'b01) ? 1'b0 : ({j, k} == 2'b11) ? ~q : q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // raw bit order: [0]=set [1]=reset [2]=toggle
  task automatic model_edge(input logic c, input logic [2:0] raw);
    logic [2:0] syn, nstb;
    logic [1:0] out;
    int ns;
    bit all_diff;
    syn = m_line1;
    out = 2'b00;
    ns = m_state;
    if (m_state == 0) begin
      if (|m_stb) begin
        m_cmd = m_stb[0] ? 2'b10 : m_stb[1] ? 2'b01 : 2'b11;
        out = m_cmd;
        ns = 1;
      end
    end else if (m_state == 1) begin
      ns = 2;
      m_hold = 0;
    end else begin
      m_hold++;
      if (m_stb == 3'b000) ns = 0;
`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
      else if (m_hold == RP && ((m_cmd == 2'b10 && m_stb[0]) || (m_cmd == 2'b01 && m_stb[1]) ||
                                (m_cmd == 2'b11 && m_stb[2]))) begin
        ns = 1;
        out = m_cmd;
      end
`endif
    end
    nstb = m_stb;
    for (int i = 0; i < 3; i++) begin
      m_win[i].push_back(syn[i]);
      if (m_win[i].size() > DB) void'(m_win[i].pop_front());
      all_diff = (m_win[i].size() == DB);
      for (int n = 0; n < m_win[i].size(); n++) all_diff &= (m_win[i][n] != m_stb[i]);
      if (all_diff) nstb[i] = ~m_stb[i];
    end
    m_line1 = m_line0;
    m_line0 = raw;
    m_stb = nstb;
    m_state = ns;
    {m_j, m_k} = out;
    m_busy = (ns != 0);
    if (c) begin
      m_line0 = '0; m_line1 = '0; m_stb = '0; m_state = 0; m_hold = 0; m_cmd = 2'b00;
      {m_j, m_k, m_busy} = 3'b000;
      for (int i = 0; i < 3; i++) m_win[i].delete();
    end
  endtask

  task automatic tick(input logic c, input logic [2:0] raw);
    clr = c;
    req_set = raw[0];
    req_reset = raw[1];
    req_toggle = raw[2];
    @(negedge clk_n);
    model_edge(c, raw);
    edge_no++;
    @(posedge clk_n);
    check("jkb", {29'b0, j, k, busy}, {29'b0, m_j, m_k, m_busy});
    if (j | k) begin
      p_edge.push_back(edge_no);
      p_val.push_back({j, k});
    end
    if (busy) begin
      if (first_busy < 0) first_busy = edge_no;
      last_busy = edge_no;
    end
  endtask

  task automatic start();
    edge_no = 0;
    first_busy = -1;
    last_busy = -1;
    p_edge.delete();
    p_val.delete();
  endtask

  task automatic press(input logic [2:0] raw, input int hold, input int idle);
    for (int n = 0; n < hold; n++) tick(1'b0, raw);
    for (int n = 0; n < idle; n++) tick(1'b0, 3'b000);
  endtask

  function automatic int pe(input int i);
    return (p_edge.size() > i) ? p_edge[i] : -1;
  endfunction

  function automatic int pv(input int i);
    return (p_val.size() > i) ? int'(p_val[i]) : -1;
  endfunction

  initial begin
    int run[3];
    logic [2:0] rv;
    repeat (3) tick(1'b1, 3'b000);
    check("reset_out", {29'b0, j, k, busy}, 32'd0);
    check("reset_q", {31'b0, q}, 32'd0);

    start();
    press(3'b100, 20, 20);
    check("t1_npulse", p_edge.size(), T1_N);
    check("t1_edge", pe(0), 7);
    check("t1_val", pv(0), 3);
    check("t1_busy_first", first_busy, 7);
    check("t1_busy_last", last_busy, 26);

    start();
    for (int r = 0; r < 4; r++) begin
      press(3'b001, 3, 1);
    end
    press(3'b001, 12, 15);
    check("t2_npulse", p_edge.size(), 1);
    check("t2_edge", pe(0), 23);
    check("t2_val", pv(0), 2);

    start();
    press(3'b101, 12, 15);
    check("t3_npulse", p_edge.size(), 1);
    check("t3_edge", pe(0), 7);
    check("t3_val", pv(0), 2);

    start();
    press(3'b010, 7, 0);
    tick(1'b1, 3'b010);
    check("t4_clr_out", {29'b0, j, k, busy}, 32'd0);
    press(3'b010, 10, 15);
    check("t4_npulse", p_edge.size(), 2);
    check("t4_edge0", pe(0), 7);
    check("t4_edge1", pe(1), 15);
    check("t4_val1", pv(1), 1);

    repeat (2) tick(1'b1, 3'b000);
    check("t5_q0", {31'b0, q}, 32'd0);
    press(3'b100, 8, 15);
    check("t5_q1", {31'b0, q}, 32'd1);
    press(3'b100, 8, 15);
    check("t5_q2", {31'b0, q}, 32'd0);
    press(3'b100, 8, 15);
    check("t5_q3", {31'b0, q}, 32'd1);

`ifdef JK_CMD_GEN_AUTO_REPEAT_EN
    start();
    press(3'b100, 60, 20);
    check("t6_npulse", p_edge.size(), 4);
    check("t6_edge0", pe(0), 7);
    check("t6_edge1", pe(1), 24);
    check("t6_edge2", pe(2), 41);
    check("t6_edge3", pe(3), 58);
`endif

    run = '{0, 0, 0};
    rv = 3'b000;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 3; b++) begin
        if (run[b] == 0) begin
          rv[b] = ~rv[b];
          run[b] = int'($urandom_range(1, 14));
        end
        run[b]--;
      end
      tick($urandom_range(0, 79) == 0, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/jk_cmd_gen.md
# jk_cmd_gen

Upstream command stage for the `jk_ff` toggle cell. Three raw, asynchronous push-button requests (set, reset, toggle) pass through synchronisation and debouncing. The block then emits exactly one clock-wide J/K command per press. Its `j`/`k` outputs connect directly to the flip-flop's `j`/`k` inputs and share its falling-edge `clk_n` domain.

## Interface
- `DB_CYCLES`, default 4: consecutive clock edges a synchronised input must differ from its debounced value before the debounced value flips; legal range ≥1.
- `REPEAT_CYCLES`, default 16: edges spent in HOLD before auto-repeat re-fires; legal range ≥2; used only with `JK_CMD_GEN_AUTO_REPEAT_EN`.
- `clk_n` — input, 1 bit: clock; every register updates on the falling edge.
- `clr` — input, 1 bit: reset, synchronous and active-high, sampled on the `clk_n` falling edge.
- `req_set` — input, 1 bit: raw set button, asynchronous, active-high.
- `req_reset` — input, 1 bit: raw reset button, asynchronous, active-high.
- `req_toggle` — input, 1 bit: raw toggle button, asynchronous, active-high.
- `j` — output, 1 bit: J command to the downstream flip-flop.
- `k` — output, 1 bit: K command to the downstream flip-flop.
- `busy` — output, 1 bit: 1 whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** each request passes through a 2-flop synchroniser; reset value 0.
- **Debouncer, per input:**
  - Holds a debounced value `stb`, reset value 0, and a counter of width `$clog2(DB_CYCLES+1)`.
  - When the synchroniser output equals `stb`, the counter clears.
  - When they differ, the counter increments. On the edge where it would reach `DB_CYCLES`, `stb` flips and the counter clears.
- **Command encoding:**
  - SET: `j`=1, `k`=0.
  - RESET: `j`=0, `k`=1.
  - TOGGLE: `j`=1, `k`=1.
  - NONE: `j`=0, `k`=0.
- **Priority** when several debounced inputs are high: SET > RESET > TOGGLE.
- **FSM states and transitions:**
  - IDLE: outputs NONE. If any `stb`=1, capture the highest-priority command and go to DRIVE.
  - DRIVE: outputs the captured command for exactly one cycle, then goes to HOLD.
  - HOLD: outputs NONE. When all three `stb`=0, go to IDLE.
- **Release rule:** a new command needs a full release first, i.e. all three `stb`=0 and the FSM back in IDLE. Pressing a second button while in HOLD has no effect.
- **Registered outputs:** `j`/`k`/`busy` are registered and change only on falling edges. They are stable for the full period the downstream flip-flop samples them.
- **Reset values:** `j`=0, `k`=0, `busy`=0, state IDLE; all synchronisers, `stb` values and counters are 0.

## Timing
- **Latency:**
  - Count the first falling edge that samples a raw input as 1 as edge 1.
  - `stb` rises after edge `DB_CYCLES`+2.
  - DRIVE is entered, with `j`/`k` valid, after edge `DB_CYCLES`+3. With the default this is edge 7.
  - The downstream flip-flop captures the command on the following falling edge.
- **Glitch rejection:** a raw pulse or bounce shorter than `DB_CYCLES` consecutive synchronised samples produces no command.
- **Release latency:** release is debounced identically, so IDLE is reached `DB_CYCLES`+3 edges after the last raw high sample.
- **Reset dominance:** `clr`=1 overrides every other condition on that edge, including mid-DRIVE, where `j`/`k` go to 0 on the next edge.
- **Button held through reset:** after `clr` deasserts, the full synchroniser and debounce delay elapses again. The block then issues one fresh command.

## Configuration
- **`JK_CMD_GEN_AUTO_REPEAT_EN` defined:**
  - HOLD runs a repeat counter that clears on HOLD entry.
  - After `REPEAT_CYCLES` edges in HOLD, if the button for the captured command still has `stb`=1, the FSM re-enters DRIVE with the same captured command.
  - Otherwise it stays in HOLD until full release.
- **Macro undefined:** no repeat counter exists; exactly one command per press.

## Structure
- **Shared package `jk_cmd_pkg`:**
  - State encoding: IDLE=2'd0, DRIVE=2'd1, HOLD=2'd2.
  - Command typedef {j,k}: CMD_NONE=2'b00, CMD_SET=2'b10, CMD_RESET=2'b01, CMD_TOGGLE=2'b11.
- **Sub-module `debounce_cell`:** 2-flop synchroniser plus debounce counter, parameterised by `DB_CYCLES`, with outputs `stb` and `rise`. It is instantiated three times.
- **Top level** holds the priority encoder, the FSM and the optional repeat counter.

## Test plan
- Reset, then `req_toggle` held for 20 edges → `j`=`k`=1 for exactly one cycle after edge 7, `busy`=1 from edge 7 until 7 edges after release.
- `req_set` bounce of 3 edges high, 1 low, repeated ×4, then steady high → no command during the bounce; a single `j`=1, `k`=0 pulse appears 7 edges after the last rising bounce.
- `req_set` and `req_toggle` rise on the same edge → one pulse, `j`=1, `k`=0; no TOGGLE follows while either is held.
- `clr` asserted on the edge DRIVE is entered, with `req_reset` held → `j`=`k`=0 next edge; after `clr` drops, one `j`=0, `k`=1 pulse occurs 7 edges later.
- Downstream `jk_ff` connected, reset, 3 toggle presses separated by full releases → `q` sequence 0→1→0→1.
- With `JK_CMD_GEN_AUTO_REPEAT_EN`, `req_toggle` held for 60 edges → pulses after edges 7, 24, 41 and 58 (period `REPEAT_CYCLES`+1 = 17).
